cond_flag_unit: RTL and testbench
=================================

# cond_flag_unit

Execute-stage condition-flag unit for the pipelined 64-bit ARM CPU. It sits directly downstream of the 64-bit add/subtract unit. It captures the N, Z, C and V outputs into the architectural NZCV register when a flag-setting instruction (ADDS/SUBS) retires from EX. It evaluates the 4-bit condition of a B.cond request against those flags, forwarding the current EX flags when the producing instruction is in the same cycle. The branch decision is registered and presented to the PC-select logic one cycle later.

## Interface
Parameters:
- none; flag and condition widths are architectural and fixed.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- alu_negative  input  1  N from the adder (Sum[63]).
- alu_zero  input  1  Z from the adder (Sum == 0).
- alu_carry  input  1  C from the adder (Cout[63]). For subtraction, 1 means no borrow.
- alu_overflow  input  1  V from the adder (Cout[62] ^ Cout[63]).
- ex_valid  input  1  the EX-stage instruction is real (not a bubble).
- set_flags  input  1  the EX-stage instruction is ADDS/SUBS.
- stall  input  1  pipeline hold; no state advances.
- flush  input  1  squash the EX instruction and any pending branch request.
- cond_valid  input  1  a B.cond evaluation is requested this cycle.
- cond_code  input  4  ARM condition field of the B.cond.
- flags_q  output  4  architectural NZCV, bit order {N,Z,C,V}.
- br_valid  output  1  br_taken holds a fresh decision.
- br_taken  output  1  the evaluated condition is true.
- br_fwd  output  1  the decision used forwarded EX flags rather than flags_q.

## Operation
- update_en = ex_valid & set_flags & ~stall & ~flush.
- fwd_en = ex_valid & set_flags & ~flush. It selects whether the evaluation uses the EX flags or flags_q.
- eval_flags = fwd_en ? {alu_negative, alu_zero, alu_carry, alu_overflow} : flags_q.
- The condition decode on eval_flags is purely combinational:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C & ~Z. 1001 LS: ~C | Z.
  - 1010 GE: N == V. 1011 LT: N != V.
  - 1100 GT: ~Z & (N == V). 1101 LE: Z | (N != V).
  - 1110 AL: 1. 1111 NV: 1 (AArch64 always).
- accept = cond_valid & ~stall & ~flush.
- Register update priority (highest first):
  - reset: flags_q = 4'b0000, br_valid = 0, br_taken = 0, br_fwd = 0.
  - flush: flags_q holds (squashed update dropped), br_valid = 0, br_taken = 0, br_fwd = 0.
  - stall: all registers hold, including br_valid.
  - otherwise:
    - flags_q loads the EX flags if update_en, else holds.
    - br_valid = accept.
    - br_taken = accept & cond_true.
    - br_fwd = accept & fwd_en.
- A non-flag-setting instruction (ADD, SUB, logic ops) never changes flags_q, even with ex_valid = 1.
- br_valid is a one-cycle pulse per accepted request. Back-to-back requests produce back-to-back pulses.

## Timing
- Flag capture latency: 1 cycle. flags_q reflects the ADDS/SUBS flags from the first rising edge after that instruction was in EX with update_en = 1.
- Branch decision latency: 1 cycle from accept to br_valid/br_taken.
- Same-cycle producer/consumer: cond_valid and fwd_en in the same cycle means the decision uses the EX flags (br_fwd = 1). flags_q is simultaneously loaded with the same flags.
- Stall cycles: the request and the flag update are both deferred; outputs are frozen. Both take effect on the first non-stalled edge, provided the inputs are still presented.
- Flush with a simultaneous stall: flush wins.
- Reset mid-operation: a pending br_valid is cleared and flags_q returns to 0000 on the same edge, regardless of stall or flush.
- There is no combinational path from inputs to any output; every output is a flop.

## Test plan
- Reset: assert reset for 2 cycles with set_flags = 1 and cond_valid = 1 -> flags_q = 0000, br_valid = 0, br_taken = 0, br_fwd = 0.
- ADDS overflow: drive N=1, Z=0, C=0, V=1 (0x7FFF_FFFF_FFFF_FFFF + 1) with ex_valid = 1, set_flags = 1 -> next cycle flags_q = 4'b1001. A B.LT (1011) in the following cycle -> br_valid = 1, br_taken = 0, br_fwd = 0.
- Forwarding: SUBS 5-5 (Z=1, C=1) in the same cycle as a B.EQ request with flags_q = 0000 -> next cycle br_taken = 1, br_fwd = 1, flags_q = 0110.
- Non-setting op: an ADD with set_flags = 0 and N=1 while flags_q = 0110 -> flags_q stays 0110. B.NE -> br_taken = 0.
- Stall then flush: SUBS plus a B.CS request held with stall = 1 for 3 cycles -> outputs unchanged during the stall. Raise flush on the 4th cycle -> br_valid = 0 and flags_q unchanged.
- Condition sweep: fix flags_q = 1010 (N=1, Z=0, C=1, V=0) and issue all 16 cond_code values back-to-back -> br_valid high for 16 consecutive cycles. br_taken sequence, codes 0 through 15: 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,1.

Source files
------------

// File: rtl/cond_flag_if.sv
// Execute-stage flag/branch bundle between the pipeline control and cond_flag_unit.
// master drives the adder flags and B.cond request; slave returns NZCV and the registered branch decision.
interface cond_flag_if;
    logic       alu_negative;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_overflow;
    logic       ex_valid;
    logic       set_flags;
    logic       stall;
    logic       flush;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic [3:0] flags_q;
    logic       br_valid;
    logic       br_taken;
    logic       br_fwd;

    modport master (
        output alu_negative, alu_zero, alu_carry, alu_overflow,
        output ex_valid, set_flags, stall, flush, cond_valid, cond_code,
        input  flags_q, br_valid, br_taken, br_fwd
    );

    modport slave (
        input  alu_negative, alu_zero, alu_carry, alu_overflow,
        input  ex_valid, set_flags, stall, flush, cond_valid, cond_code,
        output flags_q, br_valid, br_taken, br_fwd
    );
endinterface

// File: rtl/cond_flag_unit.sv
// NZCV register and B.cond evaluator for the EX stage, with same-cycle forwarding
// of ADDS/SUBS flags and a registered branch decision.
module cond_flag_unit (
    input  logic       clk,
    input  logic       reset,
    cond_flag_if.slave bus
);
    // Request/response: cond_valid is a one-shot request consumed on any edge without
    // stall or flush (no ready); br_valid is a one-cycle pulse carrying that decision.

    logic [3:0] flags_q, flags_d;
    logic       br_valid_q, br_valid_d;
    logic       br_taken_q, br_taken_d;
    logic       br_fwd_q, br_fwd_d;

    logic [3:0] ex_flags;
    logic [3:0] eval_flags;
    logic       fwd_en;
    logic       update_en;
    logic       accept;
    logic       base_true;
    logic       cond_true;
    logic       n, z, c, v;

    always_comb begin
        ex_flags   = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
        fwd_en     = bus.ex_valid & bus.set_flags & ~bus.flush;
        update_en  = fwd_en & ~bus.stall;
        accept     = bus.cond_valid & ~bus.stall & ~bus.flush;
        eval_flags = fwd_en ? ex_flags : flags_q;
        {n, z, c, v} = eval_flags;

        // Odd codes are the complement of the even code below them, except AL/NV.
        base_true = 1'b1;
        case (bus.cond_code[3:1])
            3'b000:  base_true = z;
            3'b001:  base_true = c;
            3'b010:  base_true = n;
            3'b011:  base_true = v;
            3'b100:  base_true = c & ~z;
            3'b101:  base_true = (n == v);
            3'b110:  base_true = ~z & (n == v);
            default: base_true = 1'b1;
        endcase
        cond_true = (bus.cond_code[3:1] == 3'b111) ? 1'b1 : (base_true ^ bus.cond_code[0]);
    end

    always_comb begin
        flags_d    = flags_q;
        br_valid_d = br_valid_q;
        br_taken_d = br_taken_q;
        br_fwd_d   = br_fwd_q;
        if (bus.flush) begin
            br_valid_d = 1'b0;
            br_taken_d = 1'b0;
            br_fwd_d   = 1'b0;
        end else if (!bus.stall) begin
            if (update_en) begin
                flags_d = ex_flags;
            end
            br_valid_d = accept;
            br_taken_d = accept & cond_true;
            br_fwd_d   = accept & fwd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= 4'b0000;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
            br_fwd_q   <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            br_valid_q <= br_valid_d;
            br_taken_q <= br_taken_d;
            br_fwd_q   <= br_fwd_d;
        end
    end

    assign bus.flags_q  = flags_q;
    assign bus.br_valid = br_valid_q;
    assign bus.br_taken = br_taken_q;
    assign bus.br_fwd   = br_fwd_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed scenarios and random traffic scored against
// a condition-table reference model through an expected-value queue.
module tb_cond_flag_unit;
    logic clk = 1'b0;
    logic reset;
    cond_flag_if bus ();

    cond_flag_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] exp_q[$];
    logic [3:0] m_flags;
    logic       m_bv, m_bt, m_bf;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference condition table written directly from the ARM condition mnemonics.
    function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] nzcv);
        logic nf, zf, cf, vf;
        {nf, zf, cf, vf} = nzcv;
        case (code)
            4'd0:  return zf;
            4'd1:  return !zf;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return nf;
            4'd5:  return !nf;
            4'd6:  return vf;
            4'd7:  return !vf;
            4'd8:  return cf && !zf;
            4'd9:  return !cf || zf;
            4'd10: return nf == vf;
            4'd11: return nf != vf;
            4'd12: return !zf && (nf == vf);
            4'd13: return zf || (nf != vf);
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic [3:0] nzcv, input logic exv, input logic sf,
                         input logic st, input logic fl, input logic cv, input logic [3:0] cc);
        reset = rst;
        {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} = nzcv;
        bus.ex_valid   = exv;
        bus.set_flags  = sf;
        bus.stall      = st;
        bus.flush      = fl;
        bus.cond_valid = cv;
        bus.cond_code  = cc;
    endtask

    // Predict the outcome of the coming edge, let it happen, then score it.
    task automatic cycle();
        logic [3:0] alu;
        logic       uses_ex, takes_req;
        logic [6:0] e;
        alu       = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
        uses_ex   = bus.ex_valid && bus.set_flags && !bus.flush;
        takes_req = bus.cond_valid && !bus.stall && !bus.flush;
        if (reset) begin
            m_flags = 4'b0000; m_bv = 0; m_bt = 0; m_bf = 0;
        end else if (bus.flush) begin
            m_bv = 0; m_bt = 0; m_bf = 0;
        end else if (!bus.stall) begin
            m_bt = takes_req && ref_cond(bus.cond_code, uses_ex ? alu : m_flags);
            m_bv = takes_req;
            m_bf = takes_req && uses_ex;
            if (uses_ex) m_flags = alu;
        end
        exp_q.push_back({m_flags, m_bv, m_bt, m_bf});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("flags_q",  bus.flags_q,         e[6:3]);
        check("br_valid", {3'b0, bus.br_valid}, {3'b0, e[2]});
        check("br_taken", {3'b0, bus.br_taken}, {3'b0, e[1]});
        check("br_fwd",   {3'b0, bus.br_fwd},   {3'b0, e[0]});
    endtask

    logic [15:0] sweep_exp;

    initial begin
        m_flags = 4'b0000; m_bv = 0; m_bt = 0; m_bf = 0;
        sweep_exp = 16'hE996;

        // Reset with live requests present.
        drive(1, 4'b1111, 1, 1, 0, 0, 1, 4'd14);
        cycle();
        cycle();
        check("rst_flags", bus.flags_q, 4'b0000);
        check("rst_bv", {3'b0, bus.br_valid}, 4'b0);

        // ADDS overflow, then B.LT reading the registered flags.
        drive(0, 4'b1001, 1, 1, 0, 0, 0, 4'd0);
        cycle();
        check("adds_flags", bus.flags_q, 4'b1001);
        drive(0, 4'b0000, 0, 0, 0, 0, 1, 4'd11);
        cycle();
        check("lt_res", {1'b0, bus.br_valid, bus.br_taken, bus.br_fwd}, 4'b0100);

        // SUBS 5-5 with B.EQ in the same cycle from flags 0000.
        drive(1, 4'b0000, 0, 0, 0, 0, 0, 4'd0);
        cycle();
        drive(0, 4'b0110, 1, 1, 0, 0, 1, 4'd0);
        cycle();
        check("fwd_res", {1'b0, bus.br_valid, bus.br_taken, bus.br_fwd}, 4'b0111);
        check("fwd_flags", bus.flags_q, 4'b0110);

        // Non-setting ADD with N=1 and a B.NE.
        drive(0, 4'b1000, 1, 0, 0, 0, 1, 4'd1);
        cycle();
        check("add_flags", bus.flags_q, 4'b0110);
        check("ne_taken", {3'b0, bus.br_taken}, 4'b0);

        // SUBS + B.CS held under stall, then flushed while still stalled.
        drive(0, 4'b1000, 1, 1, 1, 0, 1, 4'd2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_flags", bus.flags_q, 4'b0110);
            check("stall_bv", {3'b0, bus.br_valid}, 4'b0001);
        end
        drive(0, 4'b1000, 1, 1, 1, 1, 1, 4'd2);
        cycle();
        check("flush_bv", {3'b0, bus.br_valid}, 4'b0);
        check("flush_flags", bus.flags_q, 4'b0110);

        // Condition sweep with flags 1010.
        drive(0, 4'b1010, 1, 1, 0, 0, 0, 4'd0);
        cycle();
        check("sweep_flags", bus.flags_q, 4'b1010);
        for (int i = 0; i < 16; i++) begin
            drive(0, 4'b0000, 0, 0, 0, 0, 1, 4'(i));
            cycle();
            check("sweep_bv", {3'b0, bus.br_valid}, 4'b0001);
            check("sweep_taken", {3'b0, bus.br_taken}, {3'b0, sweep_exp[i]});
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 39) == 0,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 2) != 0,
                  4'($urandom_range(0, 15)));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
